// File: rtl/branch_cmp_pipe.sv
// Registered MIPS branch-condition resolver with valid/ready handshake and 2-entry skid buffer.
// Optional saturating result statistics when BCMP_STATS_EN is defined.
module branch_cmp_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [DATA_W-1:0] in_rs,
  input  logic [DATA_W-1:0] in_rt,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_taken,
  output logic              out_ne,
  output logic [1:0]        out_sign,
  output logic [TAG_W-1:0]  out_tag
`ifdef BCMP_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_taken,
  output logic [STAT_W-1:0] stat_total
`endif
);

  if (DATA_W < 2 || TAG_W < 1 || STAT_W < 1) begin : g_param_check
    $error("branch_cmp_pipe: DATA_W must be >= 2, TAG_W and STAT_W >= 1");
  end

  typedef enum logic [2:0] {
    OpBeq    = 3'b000,
    OpBne    = 3'b001,
    OpBlez   = 3'b010,
    OpBgtz   = 3'b011,
    OpBltz   = 3'b100,
    OpBgez   = 3'b101,
    OpAlways = 3'b110,
    OpNever  = 3'b111
  } op_e;

  typedef struct packed {
    logic             taken;
    logic             ne;
    logic [1:0]       sign;
    logic [TAG_W-1:0] tag;
  } res_t;

  logic cmp_ne, cmp_zero, cmp_neg;
  res_t cmp_res;

  always_comb begin
    cmp_ne   = (in_rs != in_rt);
    cmp_zero = (in_rs == '0);
    cmp_neg  = in_rs[DATA_W-1];

    cmp_res       = '0;
    cmp_res.ne    = cmp_ne;
    cmp_res.tag   = in_tag;
    cmp_res.sign  = cmp_zero ? 2'b00 : (cmp_neg ? 2'b10 : 2'b01);
    unique case (op_e'(in_op))
      OpBeq:    cmp_res.taken = !cmp_ne;
      OpBne:    cmp_res.taken = cmp_ne;
      OpBlez:   cmp_res.taken = cmp_zero | cmp_neg;
      OpBgtz:   cmp_res.taken = !cmp_zero & !cmp_neg;
      OpBltz:   cmp_res.taken = cmp_neg;
      OpBgez:   cmp_res.taken = !cmp_neg;
      OpAlways: cmp_res.taken = 1'b1;
      OpNever:  cmp_res.taken = 1'b0;
      default:  cmp_res.taken = 1'b0;
    endcase
  end

  logic or_valid_q, sk_valid_q, in_ready_q;
  res_t or_q, sk_q;
  logic accept, or_free;

  assign accept  = in_valid & in_ready_q;
  assign or_free = !or_valid_q | out_ready;

  // in_ready_q always mirrors !sk_valid_q, so SK is never full when a new request is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      or_valid_q <= 1'b0;
      or_q       <= '0;
      sk_valid_q <= 1'b0;
      sk_q       <= '0;
      in_ready_q <= 1'b1;
    end else if (flush) begin
      or_valid_q <= 1'b0;
      sk_valid_q <= 1'b0;
      in_ready_q <= 1'b1;
    end else if (or_free) begin
      if (sk_valid_q) begin
        or_q       <= sk_q;
        or_valid_q <= 1'b1;
        sk_valid_q <= 1'b0;
        in_ready_q <= 1'b1;
      end else if (accept) begin
        or_q       <= cmp_res;
        or_valid_q <= 1'b1;
      end else begin
        or_valid_q <= 1'b0;
      end
    end else if (accept) begin
      sk_q       <= cmp_res;
      sk_valid_q <= 1'b1;
      in_ready_q <= 1'b0;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = or_valid_q;
  assign out_taken = or_q.taken;
  assign out_ne    = or_q.ne;
  assign out_sign  = or_q.sign;
  assign out_tag   = or_q.tag;

`ifdef BCMP_STATS_EN
  logic [STAT_W-1:0] stat_taken_q, stat_total_q;
  logic              out_hs;

  assign out_hs = or_valid_q & out_ready;

  // Counters survive flush; only rst clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_taken_q <= '0;
      stat_total_q <= '0;
    end else if (out_hs) begin
      if (stat_total_q != '1) begin
        stat_total_q <= stat_total_q + 1'b1;
      end
      if (or_q.taken && (stat_taken_q != '1)) begin
        stat_taken_q <= stat_taken_q + 1'b1;
      end
    end
  end

  assign stat_taken = stat_taken_q;
  assign stat_total = stat_total_q;
`endif

endmodule

// File: tb/tb_branch_cmp_pipe.sv
// Self-checking bench for branch_cmp_pipe: directed scenarios plus randomized traffic
// compared against a 2-deep FIFO reference model using signed arithmetic.
module tb_branch_cmp_pipe;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned TAG_W  = 4;
  localparam int unsigned STAT_W = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic              out_taken, out_ne;
  logic [2:0]        in_op;
  logic [DATA_W-1:0] in_rs, in_rt;
  logic [TAG_W-1:0]  in_tag, out_tag;
  logic [1:0]        out_sign;
`ifdef BCMP_STATS_EN
  logic [STAT_W-1:0] stat_taken, stat_total;
`endif

  branch_cmp_pipe #(
    .DATA_W(DATA_W),
    .TAG_W (TAG_W),
    .STAT_W(STAT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_rs    (in_rs),
    .in_rt    (in_rt),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_taken(out_taken),
    .out_ne   (out_ne),
    .out_sign (out_sign),
    .out_tag  (out_tag)
`ifdef BCMP_STATS_EN
    ,
    .stat_taken(stat_taken),
    .stat_total(stat_total)
`endif
  );

  typedef struct {
    logic             taken;
    logic             ne;
    logic [1:0]       sign;
    logic [TAG_W-1:0] tag;
  } res_t;

  res_t             mdl_q[$];
  logic [TAG_W-1:0] out_log[$];
  int unsigned      n_total = 0;
  int unsigned      n_bad   = 0;
  int unsigned      mdl_stat_total = 0;
  int unsigned      mdl_stat_taken = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic res_t ref_result(input logic [2:0] op, input logic [DATA_W-1:0] rs,
                                      input logic [DATA_W-1:0] rt, input logic [TAG_W-1:0] tag);
    res_t r;
    longint s;
    s = longint'($signed(rs));
    r.tag  = tag;
    r.ne   = (rs != rt);
    r.sign = (s == 0) ? 2'b00 : ((s < 0) ? 2'b10 : 2'b01);
    case (op)
      3'd0:    r.taken = (rs == rt);
      3'd1:    r.taken = (rs != rt);
      3'd2:    r.taken = (s <= 0);
      3'd3:    r.taken = (s > 0);
      3'd4:    r.taken = (s < 0);
      3'd5:    r.taken = (s >= 0);
      3'd6:    r.taken = 1'b1;
      default: r.taken = 1'b0;
    endcase
    return r;
  endfunction

  task automatic compare_model();
    check("in_ready", in_ready, mdl_q.size() < 2);
    check("out_valid", out_valid, mdl_q.size() != 0);
    if (mdl_q.size() != 0) begin
      check("out_taken", out_taken, mdl_q[0].taken);
      check("out_ne", out_ne, mdl_q[0].ne);
      check("out_sign", out_sign, mdl_q[0].sign);
      check("out_tag", out_tag, mdl_q[0].tag);
    end
`ifdef BCMP_STATS_EN
    check("stat_total", stat_total, mdl_stat_total);
    check("stat_taken", stat_taken, mdl_stat_taken);
`endif
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then compare.
  task automatic step(input logic v, input logic [2:0] op, input logic [DATA_W-1:0] rs,
                      input logic [DATA_W-1:0] rt, input logic [TAG_W-1:0] tag,
                      input logic ordy, input logic fl, input logic r);
    bit hs, acc;
    int unsigned smax;
    smax = (1 << STAT_W) - 1;
    in_valid = v; in_op = op; in_rs = rs; in_rt = rt; in_tag = tag;
    out_ready = ordy; flush = fl; rst = r;
    hs  = (mdl_q.size() != 0) && ordy;
    acc = v && (mdl_q.size() < 2);
    @(posedge clk);
    if (r) begin
      mdl_q.delete();
      mdl_stat_total = 0;
      mdl_stat_taken = 0;
    end else begin
      if (hs) begin
        if (mdl_stat_total < smax) mdl_stat_total++;
        if (mdl_q[0].taken && mdl_stat_taken < smax) mdl_stat_taken++;
        out_log.push_back(mdl_q[0].tag);
      end
      if (fl) begin
        mdl_q.delete();
      end else begin
        if (hs) void'(mdl_q.pop_front());
        if (acc) mdl_q.push_back(ref_result(op, rs, rt, tag));
      end
    end
    @(negedge clk);
    compare_model();
  endtask

  task automatic send(input logic [2:0] op, input logic [DATA_W-1:0] rs,
                      input logic [DATA_W-1:0] rt, input logic [TAG_W-1:0] tag,
                      input logic ordy);
    step(1'b1, op, rs, rt, tag, ordy, 1'b0, 1'b0);
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 3'd0, '0, '0, '0, ordy, 1'b0, 1'b0);
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_valid"}, out_valid, 1'b0);
    check({name, "_taken"}, out_taken, 1'b0);
    check({name, "_ne"}, out_ne, 1'b0);
    check({name, "_sign"}, out_sign, 2'b00);
    check({name, "_tag"}, out_tag, '0);
    check({name, "_ready"}, in_ready, 1'b1);
  endtask

  logic [DATA_W-1:0] sweep_rs[3] = '{32'h0000_0000, 32'h8000_0000, 32'h0000_0001};
  logic [2:0]        sweep_tk[4] = '{3'b110, 3'b001, 3'b010, 3'b101};
  logic [1:0]        sweep_sg[3] = '{2'b00, 2'b10, 2'b01};

  initial begin
    logic [DATA_W-1:0] rs, rt;
    int unsigned sel;

    @(negedge clk);
    step(1'b0, 3'd0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
    check_reset_values("reset");

    send(3'd0, 32'h1234_5678, 32'h1234_5678, 4'h1, 1'b1);
    check("beq_valid", out_valid, 1'b1);
    check("beq_taken", out_taken, 1'b1);
    check("beq_ne", out_ne, 1'b0);
    check("beq_sign", out_sign, 2'b01);

    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 3; j++) begin
        send(3'(i + 2), sweep_rs[j], $urandom, 4'(j), 1'b1);
        check($sformatf("sweep_op%0d_rs%0d_taken", i + 2, j), out_taken, sweep_tk[i][2-j]);
        check($sformatf("sweep_op%0d_rs%0d_sign", i + 2, j), out_sign, sweep_sg[j]);
      end
    end
    idle(1'b1);

    send(3'd6, 32'd5, 32'd5, 4'd1, 1'b0);
    send(3'd6, 32'd5, 32'd5, 4'd2, 1'b0);
    send(3'd6, 32'd5, 32'd5, 4'd3, 1'b0);
    check("bp_or_tag", out_tag, 4'd1);
    check("bp_in_ready", in_ready, 1'b0);
    out_log.delete();
    send(3'd6, 32'd5, 32'd5, 4'd3, 1'b1);
    send(3'd6, 32'd5, 32'd5, 4'd3, 1'b1);
    for (int k = 0; k < 3; k++) idle(1'b1);
    check("bp_count", out_log.size(), 3);
    for (int k = 0; k < 3 && k < out_log.size(); k++) begin
      check($sformatf("bp_order%0d", k), out_log[k], 4'(k + 1));
    end

    send(3'd6, 32'd0, 32'd0, 4'd6, 1'b0);
    send(3'd6, 32'd0, 32'd0, 4'd7, 1'b0);
    step(1'b1, 3'd6, '0, '0, 4'd5, 1'b0, 1'b1, 1'b0);
    check("flush_valid", out_valid, 1'b0);
    check("flush_ready", in_ready, 1'b1);
    for (int k = 0; k < 3; k++) idle(1'b1);
    check("flush_dropped", out_valid, 1'b0);

    send(3'd6, 32'd0, 32'd0, 4'd8, 1'b0);
    send(3'd6, 32'd0, 32'd0, 4'd9, 1'b0);
    step(1'b1, 3'd6, '0, '0, 4'd4, 1'b0, 1'b0, 1'b1);
    check_reset_values("midrst");
    send(3'd1, 32'd1, 32'd2, 4'hA, 1'b1);
    check("bne_taken", out_taken, 1'b1);
    check("bne_ne", out_ne, 1'b1);
    check("bne_sign", out_sign, 2'b01);
    idle(1'b1);

`ifdef BCMP_STATS_EN
    step(1'b0, 3'd0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) send((k == 2) ? 3'd7 : 3'd6, '0, '0, 4'(k), 1'b1);
    idle(1'b1);
    idle(1'b1);
    check("stat_total_sat", stat_total, 2'd3);
    check("stat_taken_sat", stat_taken, 2'd3);
    step(1'b0, 3'd0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
    check("stat_total_flush", stat_total, 2'd3);
    check("stat_taken_flush", stat_taken, 2'd3);
`endif

    for (int n = 0; n < 600; n++) begin
      sel = $urandom_range(0, 3);
      rt  = $urandom;
      case (sel)
        0:       rs = '0;
        1:       rs = 32'h8000_0000 | $urandom;
        2:       rs = $urandom;
        default: rs = rt;
      endcase
      step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), rs, rt, 4'($urandom),
           $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
